// File: rtl/lisp_core_pkg.sv
// Shared definitions for the Lisp evaluator core: word fields, type and error
// codes, the evaluator state encoding and the hex-to-seven-segment decoder.
package lisp_defs;

    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 8;
    localparam int TYPE_W      = 3;
    localparam int WORD_ADDR_W = 12;

    localparam logic [TYPE_W-1:0] TYPE_NIL    = 3'd0;
    localparam logic [TYPE_W-1:0] TYPE_NUMBER = 3'd1;
    localparam logic [TYPE_W-1:0] TYPE_CONS   = 3'd2;

    localparam logic [DATA_W-1:0] LISP_NIL = 16'h0000;

    localparam logic [7:0] ERR_NONE       = 8'h00;
    localparam logic [7:0] ERR_BAD_TYPE   = 8'h01;
    localparam logic [7:0] ERR_ADDR_RANGE = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // Active-low segments {dp,g,f,e,d,c,b,a}; decimal point always off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/lisp_memory.sv
// Single-port tagged word memory with synchronous write and synchronous read.
// Contents are deliberately left out of reset.
module lisp_memory
    import lisp_defs::*;
#(
    parameter int MEM_SIZE = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] memory [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            memory[addr] <= wdata;
        end
        if (re) begin
            rdata <= memory[addr];
        end
    end

endmodule

// File: rtl/lisp_core.sv
// Lisp evaluator core: evaluates the word on the switches against tagged memory.
// Define LISP_SEVEN_SEG_EN to build the multiplexed 4-digit hex display.
module lisp_core
    import lisp_defs::*;
#(
    parameter int MEM_SIZE     = 256,
    parameter int REFRESH_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic [15:0] switches,
    output logic [7:0]  cathodes,
    output logic [3:0]  anodes,
    output logic [15:0] leds
);

    localparam logic [WORD_ADDR_W:0] MEM_LIMIT = (WORD_ADDR_W + 1)'(MEM_SIZE);

    state_t            state;
    logic [DATA_W-1:0] val;
    logic [7:0]        error;
    logic [DATA_W-1:0] expr;
    logic              btn_q;
    logic              start_edge;
    logic [DATA_W-1:0] mem_rdata;

    logic [TYPE_W-1:0]      word_type;
    logic [WORD_ADDR_W-1:0] word_addr;
    logic                   type_valid;
    logic                   addr_ok;

    assign start_edge = btn_start & ~btn_q;
    assign word_type  = expr[14:12];
    assign word_addr  = expr[WORD_ADDR_W-1:0];
    assign type_valid = (word_type == TYPE_NIL) || (word_type == TYPE_NUMBER) ||
                        (word_type == TYPE_CONS);
    assign addr_ok    = {1'b0, word_addr} < MEM_LIMIT;

    lisp_memory #(
        .MEM_SIZE(MEM_SIZE)
    ) mem (
        .clk  (clk),
        .we   (1'b0),
        .re   (state == ST_FETCH),
        .addr (expr[ADDR_W-1:0]),
        .wdata(LISP_NIL),
        .rdata(mem_rdata)
    );

    // btn_q resets high so a press held through reset is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            val   <= '0;
            error <= ERR_NONE;
            expr  <= '0;
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn_start;
            case (state)
                ST_IDLE, ST_HALT, ST_ERROR: begin
                    if (start_edge) begin
                        expr  <= switches;
                        error <= ERR_NONE;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (expr[15] || !type_valid) begin
                        error <= ERR_BAD_TYPE;
                        state <= ST_ERROR;
                    end else if (word_type != TYPE_NUMBER) begin
                        val   <= expr;
                        state <= ST_HALT;
                    end else if (!addr_ok) begin
                        error <= ERR_ADDR_RANGE;
                        state <= ST_ERROR;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: state <= ST_EVAL;
                ST_EVAL: begin
                    val   <= mem_rdata;
                    state <= ST_HALT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        leds = switches;
        case (state)
            ST_HALT:  leds = val;
            ST_ERROR: leds = {8'h80, error};
            default:  leds = switches;
        endcase
    end

`ifdef LISP_SEVEN_SEG_EN
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              digit_sel;
    logic [3:0]              digit_nib;

    assign digit_sel = refresh_cnt[REFRESH_BITS-1 -: 2];

    always_comb begin
        digit_nib = leds[3:0];
        case (digit_sel)
            2'd0: digit_nib = leds[3:0];
            2'd1: digit_nib = leds[7:4];
            2'd2: digit_nib = leds[11:8];
            default: digit_nib = leds[15:12];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            anodes      <= 4'hF;
            cathodes    <= 8'hFF;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            anodes      <= ~(4'b0001 << digit_sel);
            cathodes    <= hex_to_seg(digit_nib);
        end
    end
`else
    assign cathodes = 8'hFF;
    assign anodes   = 4'hF;
`endif

endmodule

// File: tb/tb_lisp_core.sv
// Directed bench for lisp_core: evaluation paths, latencies, errors, button and
// reset handling, and the display scan when LISP_SEVEN_SEG_EN is defined.
module tb_lisp_core;
    import lisp_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start;
    logic [15:0] switches;
    logic [7:0]  cathodes;
    logic [3:0]  anodes;
    logic [15:0] leds;

    int nvec  = 0;
    int nmiss = 0;

    always #5 clk = ~clk;

    lisp_core #(
        .MEM_SIZE    (256),
        .REFRESH_BITS(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_start(btn_start),
        .switches (switches),
        .cathodes (cathodes),
        .anodes   (anodes),
        .leds     (leds)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmiss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a word with a one-cycle press and stop `cycles` clocks after the edge.
    task automatic eval_word(input logic [15:0] w, input int cycles);
        @(negedge clk);
        switches  = w;
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        repeat (cycles - 1) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        btn_start = 1'b0;
        switches  = 16'h1234;
        #1;
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        chk("rst_val",   32'(dut.val),   32'h0);
        chk("rst_error", 32'(dut.error), 32'h0);
        chk("rst_leds",  32'(leds),      32'h1234);
        chk("rst_anodes", 32'(anodes),   32'hF);
        chk("rst_cathodes", 32'(cathodes), 32'hFF);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_leds", 32'(leds), 32'h1234);

        dut.mem.memory[1]   = 16'hDEAD;
        dut.mem.memory[255] = 16'hA5A5;

        // NUMBER: four cycles from the edge, value read raw from memory
        eval_word(16'h1001, 3);
        chk("num_eval_cyc3", 32'(dut.state), 32'(ST_EVAL));
        @(negedge clk);
        chk("num_state", 32'(dut.state), 32'(ST_HALT));
        chk("num_val",   32'(dut.val),   32'hDEAD);
        chk("num_leds",  32'(leds),      32'hDEAD);
        chk("num_error", 32'(dut.error), 32'h0);

`ifdef LISP_SEVEN_SEG_EN
        begin
            logic [3:0] exp_an [4];
            logic [7:0] exp_ca [4];
            logic [3:0] prev;
            int t;
            exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
            exp_ca = '{8'hA1, 8'h88, 8'h86, 8'hA1};
            t = 0;
            while (anodes !== 4'b1110 && t < 64) begin
                @(negedge clk);
                t++;
            end
            chk("disp_an0", 32'(anodes),   32'(exp_an[0]));
            chk("disp_ca0", 32'(cathodes), 32'(exp_ca[0]));
            for (int i = 1; i < 4; i++) begin
                prev = anodes;
                t = 0;
                while (anodes === prev && t < 64) begin
                    @(negedge clk);
                    t++;
                end
                chk("disp_an", 32'(anodes),   32'(exp_an[i]));
                chk("disp_ca", 32'(cathodes), 32'(exp_ca[i]));
            end
        end
`else
        chk("disp_off_cathodes", 32'(cathodes), 32'hFF);
        chk("disp_off_anodes",   32'(anodes),   32'hF);
`endif

        // CONS is self-evaluating: two cycles, no memory access
        dut.mem.memory[1] = 16'hBEEF;
        dut.mem.memory[2] = 16'hDEAD;
        dut.mem.memory[3] = 16'h0001;
        dut.mem.memory[4] = 16'h0002;
        eval_word(16'h2004, 2);
        chk("cons_state", 32'(dut.state), 32'(ST_HALT));
        chk("cons_val",   32'(dut.val),   32'h2004);
        chk("cons_leds",  32'(leds),      32'h2004);

        eval_word(16'h5000, 2);
        chk("badtype_state", 32'(dut.state), 32'(ST_ERROR));
        chk("badtype_error", 32'(dut.error), 32'h01);
        chk("badtype_leds",  32'(leds),      32'h8001);

        eval_word(16'h0000, 2);
        chk("nil_state", 32'(dut.state), 32'(ST_HALT));
        chk("nil_val",   32'(dut.val),   32'h0);
        chk("nil_error", 32'(dut.error), 32'h0);

        eval_word(16'h8000, 2);
        chk("bit15_state", 32'(dut.state), 32'(ST_ERROR));
        chk("bit15_error", 32'(dut.error), 32'h01);

        eval_word(16'h1100, 2);
        chk("range_state", 32'(dut.state), 32'(ST_ERROR));
        chk("range_error", 32'(dut.error), 32'h02);
        chk("range_leds",  32'(leds),      32'h8002);

        eval_word(16'h10FF, 4);
        chk("top_addr_state", 32'(dut.state), 32'(ST_HALT));
        chk("top_addr_val",   32'(dut.val),   32'hA5A5);
        chk("top_addr_error", 32'(dut.error), 32'h0);

        // Held button: memory changes after the first result; a re-evaluation would show it
        @(negedge clk);
        switches  = 16'h1002;
        btn_start = 1'b1;
        repeat (4) @(negedge clk);
        chk("held_first_state", 32'(dut.state), 32'(ST_HALT));
        chk("held_first_val",   32'(dut.val),   32'hDEAD);
        dut.mem.memory[2] = 16'h1234;
        repeat (6) @(negedge clk);
        btn_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_state", 32'(dut.state), 32'(ST_HALT));
        chk("held_val",   32'(dut.val),   32'hDEAD);

        // Reset in Wait drops the evaluation and clears val
        eval_word(16'h1001, 2);
        chk("midrst_pre_state", 32'(dut.state), 32'(ST_WAIT));
        rst = 1'b1;
        #1;
        chk("midrst_state", 32'(dut.state), 32'(ST_IDLE));
        chk("midrst_val",   32'(dut.val),   32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Press held through reset must not start an evaluation
        @(negedge clk);
        btn_start = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("heldrst_state", 32'(dut.state), 32'(ST_IDLE));
        btn_start = 1'b0;
        @(negedge clk);
        eval_word(16'h1001, 4);
        chk("recover_state", 32'(dut.state), 32'(ST_HALT));
        chk("recover_val",   32'(dut.val),   32'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule

// File: doc/lisp_core.md
# lisp_core

Top-level evaluator core of the Lisp machine. An operator sets a 16-bit tagged Lisp word on the switches and presses start. The core evaluates that word against a 256-word tagged memory and halts with the result in `val`, or enters an error state. The result drives the LEDs and, optionally, a 4-digit seven-segment display.

## Interface
Reset and clocking (fixed): one clock; reset is asynchronous and active-high.

Parameters:
- `MEM_SIZE`, 256: number of 16-bit memory words.
- `REFRESH_BITS`, 16: width of the display-refresh counter; digit select is its top 2 bits.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `btn_start`  in  1: start button, level input.
- `switches`  in  16: expression word to evaluate.
- `cathodes`  out  8: seven-segment segments, active-low, {dp,g,f,e,d,c,b,a}.
- `anodes`  out  4: digit enables, active-low; anode 0 is the least-significant digit.
- `leds`  out  16: result/status display.

## Operation
Word format: [15] reserved, must be 0; [14:12] type; [11:0] address.

Types (package constants):
- `TYPE_NIL`=0
- `TYPE_NUMBER`=1
- `TYPE_CONS`=2
- 3–7 are invalid.

`LISP_NIL`=16'h0000.

Cons cell at address A: car pointer in `memory[A]`, cdr pointer in `memory[A-1]`.

Internal signals, probed by name:
- `state`
- `val[15:0]`
- `error[7:0]`
- memory instance `mem`, containing array `memory[MEM_SIZE]`.

State machine `state` has states Idle, Fetch, Wait, Eval, Halt, Error.
- Idle/Halt/Error: a rising edge of `btn_start` latches `switches` into `expr` and goes to Fetch.
- Fetch: decode `expr`.
  - Bit 15 set, or type invalid → Error with `error`=`ERR_BAD_TYPE` (8'h01).
  - NIL or CONS → `val`=`expr`, go to Halt. These types are self-evaluating; no memory read.
  - NUMBER: address ≥ `MEM_SIZE` → Error with `ERR_ADDR_RANGE` (8'h02). Otherwise issue a read of `memory[addr]` and go to Wait.
- Wait: one cycle for the synchronous read.
- Eval: `val` = read data, raw 16 bits and not type-checked. Go to Halt.
- Leaving Idle/Halt/Error clears `error` to `ERR_NONE` (8'h00).

Outputs:
- `leds`: Idle → `switches`; Halt → `val`; Error → {8'h80, `error`}.
- Display shows `leds` as 4 hex digits.

Memory:
- Synchronous write and synchronous read.
- The core never writes memory; the write port is reserved.
- Contents are not affected by `rst`.

## Timing
- Reset values: `state`=Idle, `val`=0, `error`=0, `expr`=0, refresh counter 0. `leds`=`switches`; `anodes`=4'b1111 until the first refresh step.
- `btn_start` is registered once; edge = current & ~previous. A press held across reset generates no edge until it is released and pressed again.
- Counting from the edge-detect cycle:
  - NIL/CONS/errors reach Halt/Error after 2 cycles.
  - NUMBER reaches Halt after 4 cycles.
- A press during Fetch/Wait/Eval is ignored.
- Reset asserted mid-evaluation returns to Idle immediately; no partial `val` survives.

## Configuration
`LISP_SEVEN_SEG_EN`:
- Defined: the refresh counter multiplexes the 4 digits, one anode low at a time, with the hex-to-segment decoder driving `cathodes`.
- Undefined: `cathodes`=8'hFF and `anodes`=4'hF constantly, and no refresh logic is built.

`leds` behaviour is identical either way.

## Structure
- Package `lisp_defs`: type codes, `LISP_NIL`, error codes, word-field widths, state enum.
- Sub-module `lisp_memory`, instanced as `mem`: 8-bit address, 16-bit data, single-port synchronous RAM with array `memory`.
- Hex-to-segment decoding is a function in the package, not a module.

## Test plan
- NUMBER: `memory[1]`=DEAD, `switches`=16'h1001, press → Halt, `val`=16'hDEAD, `leds`=16'hDEAD.
- CONS: `memory[1..4]`={BEEF, DEAD, 0001, 0002}, `switches`=16'h2004, press → Halt, `val`=16'h2004.
- Invalid type: `switches`=16'h5000 → Error, `error`=8'h01, `leds`=16'h8001. Then `switches`=16'h0000, press → Halt, `val`=0, `error`=0.
- Range: `MEM_SIZE`=256, `switches`=16'h1100 → Error, `error`=8'h02.
- Held button: `btn_start` held high for 10 cycles → exactly one evaluation. Reset asserted during Wait → Idle, `val`=0.
- Display (`LISP_SEVEN_SEG_EN` defined): after Halt with `val`=DEAD, the anodes cycle 1110→1101→1011→0111 with `cathodes` decoding D,A,E,D respectively.
